// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: main+skid entries, registered s_ready, sync flush.
// Optional perf counters enabled by defining PIPE_PERF_EN.
module pipe_stage_elastic #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              s_fire;
  logic              m_fire;

  assign s_fire = s_valid & s_ready;
  assign m_fire = m_valid & m_ready;
  assign m_data = main_q;

  // Occupancy FSM; handshake flags are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      m_valid <= 1'b0;
      s_ready <= 1'b1;
    end else if (flush_i) begin
      state   <= EMPTY;
      m_valid <= 1'b0;
      s_ready <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (s_fire) begin
            main_q  <= s_data;
            state   <= ONE;
            m_valid <= 1'b1;
          end
        end
        ONE: begin
          unique case (1'b1)
            s_fire && m_fire: begin
              main_q <= s_data;
            end
            s_fire && !m_fire: begin
              skid_q  <= s_data;
              state   <= TWO;
              s_ready <= 1'b0;
            end
            !s_fire && m_fire: begin
              state   <= EMPTY;
              m_valid <= 1'b0;
            end
            default: ;
          endcase
        end
        TWO: begin
          if (m_fire) begin
            main_q  <= skid_q;
            state   <= ONE;
            s_ready <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          m_valid <= 1'b0;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_EN
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating stall/bubble counters, sampled from pre-edge handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (m_valid && !m_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CntOne;
      if (!m_valid && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + CntOne;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: queue model, directed cases, random traffic.
// Define PIPE_PERF_EN to also exercise the perf counters (CNT_W=4).
module tb_pipe_stage_elastic;

  localparam int          DW   = 32;
  localparam logic [31:0] RV   = 32'hDEAD_BEEF;
  localparam int          CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush_i = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
`ifdef PIPE_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;
`endif

  int vectors = 0;
  int errors  = 0;

  pipe_stage_elastic #(
    .DATA_W    (DW),
    .RESET_VAL (RV),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
`ifdef PIPE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a bounded FIFO of held payloads.
  logic [DW-1:0] q[$];
  logic [DW-1:0] shown = RV;
  int            m_stall = 0;
  int            m_bubble = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      shown    = RV;
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      automatic bit sf = s_valid && (q.size() < 2);
      automatic bit mf = (q.size() > 0) && m_ready;
      if (q.size() > 0 && !m_ready && m_stall < CMAX) m_stall++;
      if (q.size() == 0 && m_bubble < CMAX) m_bubble++;
      if (flush_i) begin
        q.delete();
      end else begin
        if (mf) void'(q.pop_front());
        if (sf) q.push_back(s_data);
      end
      if (q.size() > 0) shown = q[0];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare of DUT against model, away from the active edge.
  always @(negedge clk) begin
    chk("m_valid", {31'd0, m_valid}, {31'd0, q.size() > 0});
    chk("s_ready", {31'd0, s_ready}, {31'd0, q.size() < 2});
    chk("m_data", m_data, shown);
`ifdef PIPE_PERF_EN
    chk("stall_cnt", {28'd0, stall_cnt}, m_stall);
    chk("bubble_cnt", {28'd0, bubble_cnt}, m_bubble);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    s_valid = 1'b1;
    s_data  = d;
    step();
    s_valid = 1'b0;
  endtask

  initial begin
    // Reset
    #1 rst_n = 1'b0;
    #2;
    chk("rst_mv", {31'd0, m_valid}, 32'd0);
    chk("rst_sr", {31'd0, s_ready}, 32'd1);
    chk("rst_md", m_data, RV);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("idle_mv", {31'd0, m_valid}, 32'd0);
    chk("idle_md", m_data, RV);

    // Streaming 1..8
    m_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      s_valid = 1'b1;
      s_data  = k;
      step();
      chk("strm_md", m_data, k);
      chk("strm_mv", {31'd0, m_valid}, 32'd1);
      chk("strm_sr", {31'd0, s_ready}, 32'd1);
    end
    s_valid = 1'b0;
    step();
    chk("strm_end", {31'd0, m_valid}, 32'd0);

    // Backpressure
    m_ready = 1'b0;
    push(32'hA);
    push(32'hB);
    chk("bp_sr", {31'd0, s_ready}, 32'd0);
    chk("bp_md", m_data, 32'hA);
    step();
    chk("bp_hold", m_data, 32'hA);
    m_ready = 1'b1;
    step();
    chk("bp_pop1", m_data, 32'hB);
    chk("bp_sr1", {31'd0, s_ready}, 32'd1);
    step();
    chk("bp_pop2", {31'd0, m_valid}, 32'd0);

    // Flush while full, with a discarded push
    m_ready = 1'b0;
    push(32'h11);
    push(32'h22);
    s_valid = 1'b1;
    s_data  = 32'h33;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    s_valid = 1'b0;
    chk("fl_mv", {31'd0, m_valid}, 32'd0);
    chk("fl_sr", {31'd0, s_ready}, 32'd1);
    chk("fl_md", m_data, 32'h11);
    m_ready = 1'b1;
    step();
    chk("fl_gone", {31'd0, m_valid}, 32'd0);

    // Async reset while full
    m_ready = 1'b0;
    push(32'h1);
    push(32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_mv", {31'd0, m_valid}, 32'd0);
    chk("ar_sr", {31'd0, s_ready}, 32'd1);
    chk("ar_md", m_data, RV);
    #1 rst_n = 1'b1;
    step();
    m_ready = 1'b1;
    push(32'h5);
    chk("ar_restart", m_data, 32'h5);
    chk("ar_restart_v", {31'd0, m_valid}, 32'd1);

`ifdef PIPE_PERF_EN
    // Counters: 3 bubbles, then 20 stalls saturating at 15
    m_ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    chk("pc_bub3", {28'd0, bubble_cnt}, 32'd3);
    push(32'h77);
    for (int i = 0; i < 20; i++) step();
    chk("pc_stall", {28'd0, stall_cnt}, 32'd15);
    chk("pc_bub4", {28'd0, bubble_cnt}, 32'd4);
`endif

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = $urandom;
      m_ready = ($urandom_range(0, 2) != 0);
      flush_i = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      step();
    end
    s_valid = 1'b0;
    flush_i = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
